input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 156 +++++++++++++++
 tb/tb_input_conditioner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Button/switch front end: 2-flop sync, per-channel debounce,
// and per-button press/auto-repeat pulse generation.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int REPEAT_DELAY    = 13500000,
  parameter int REPEAT_RATE     = 2700000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  input  logic [6:0] sw_raw,
  input  logic       repeat_en,
  output logic [3:0] btn_pulse,
  output logic [3:0] btn_level,
  output logic [6:0] sw_level
);

  localparam int N    = 11;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX);

  localparam logic [N-1:0]  REL     = {7'b0, 4'hf};
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RR_LAST = TW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD_DELAY,
    HELD_REPEAT
  } state_t;

  logic [N-1:0] meta;
  logic [N-1:0] sync;
  logic [N-1:0] active;
  logic [N-1:0] level;
  logic [3:0]   rise;
  logic [3:0]   fall;

  // Synchronizers reset to the released/off raw pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= REL;
      sync <= REL;
    end else begin
      meta <= {sw_raw, btn_raw};
      sync <= meta;
    end
  end

  assign active = sync ^ REL;

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          hit;

    assign hit      = (active[g] != lvl) && (cnt == DB_LAST);
    assign level[g] = lvl;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (active[g] == lvl) begin
        cnt <= '0;
      end else if (hit) begin
        cnt <= '0;
        lvl <= active[g];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    // Buttons need the acceptance edge itself so the first
    // pulse lands on the same clock as btn_level.
    if (g < 4) begin : g_evt
      assign rise[g] = hit & active[g];
      assign fall[g] = hit & ~active[g];
    end
  end

  assign btn_level = level[3:0];
  assign sw_level  = level[10:4];

  for (genvar b = 0; b < 4; b++) begin : g_btn
    state_t        st;
    state_t        st_nx;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_nx;
    logic          pls;
    logic          pls_nx;

    always_comb begin
      st_nx  = st;
      tmr_nx = tmr;
      pls_nx = 1'b0;
      case (st)
        IDLE: begin
          if (rise[b]) begin
            st_nx  = HELD_DELAY;
            tmr_nx = '0;
            pls_nx = 1'b1;
          end
        end
        HELD_DELAY: begin
          if (fall[b]) begin
            st_nx  = IDLE;
            tmr_nx = '0;
          end else if (tmr == RD_LAST) begin
            if (repeat_en) begin
              st_nx  = HELD_REPEAT;
              tmr_nx = '0;
              pls_nx = 1'b1;
            end
          end else begin
            tmr_nx = tmr + TW'(1);
          end
        end
        HELD_REPEAT: begin
          // Timer keeps its cadence while repeats are masked.
          if (fall[b]) begin
            st_nx  = IDLE;
            tmr_nx = '0;
          end else if (tmr == RR_LAST) begin
            tmr_nx = '0;
            pls_nx = repeat_en;
          end else begin
            tmr_nx = tmr + TW'(1);
          end
        end
        default: begin
          st_nx  = IDLE;
          tmr_nx = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st  <= IDLE;
        tmr <= '0;
        pls <= 1'b0;
      end else begin
        st  <= st_nx;
        tmr <= tmr_nx;
        pls <= pls_nx;
      end
    end

    assign btn_pulse[b] = pls;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random
// stimulus checked against an event-scheduled reference model.
module tb_input_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [6:0] sw_raw;
  logic       repeat_en;
  logic [3:0] btn_pulse;
  logic [3:0] btn_level;
  logic [6:0] sw_level;

  int vectors = 0;
  int errors  = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .sw_raw(sw_raw),
    .repeat_en(repeat_en),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level),
    .sw_level(sw_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: raw inputs delayed two clocks, a level flips
  // once the last D observed samples all oppose it, and repeat
  // pulses are scheduled as absolute cycle deadlines.
  localparam bit [10:0] REL = {7'b0, 4'hf};
  bit [10:0]  p1, p2, mlev;
  bit [D-1:0] hist [11];
  int         phase [4];
  longint     cand [4];
  longint     n;
  bit [3:0]   mpulse;

  function automatic void model_reset();
    p1 = REL;
    p2 = REL;
    mlev = '0;
    mpulse = '0;
    for (int i = 0; i < 11; i++) hist[i] = '0;
    for (int i = 0; i < 4; i++) begin
      phase[i] = 0;
      cand[i] = 0;
    end
  endfunction

  function automatic void model_step();
    bit [10:0]  seen;
    bit [3:0]   rise, fall;
    bit [D-1:0] ones, zeros;
    ones = '1;
    zeros = '0;
    rise = '0;
    fall = '0;
    seen = p2 ^ REL;
    p2 = p1;
    p1 = {sw_raw, btn_raw};
    n++;
    for (int c = 0; c < 11; c++) begin
      hist[c] = {hist[c][D-2:0], seen[c]};
      if (!mlev[c] && hist[c] == ones) begin
        mlev[c] = 1'b1;
        if (c < 4) rise[c] = 1'b1;
      end else if (mlev[c] && hist[c] == zeros) begin
        mlev[c] = 1'b0;
        if (c < 4) fall[c] = 1'b1;
      end
    end
    for (int b = 0; b < 4; b++) begin
      mpulse[b] = 1'b0;
      if (rise[b]) begin
        phase[b] = 1;
        cand[b] = n + RD;
        mpulse[b] = 1'b1;
      end else if (fall[b]) begin
        phase[b] = 0;
      end else if (phase[b] == 1 && n >= cand[b] && repeat_en) begin
        phase[b] = 2;
        cand[b] = n + RR;
        mpulse[b] = 1'b1;
      end else if (phase[b] == 2 && n == cand[b]) begin
        mpulse[b] = repeat_en;
        cand[b] = cand[b] + RR;
      end
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    check("btn_pulse", btn_pulse, mpulse);
    check("btn_level", btn_level, mlev[3:0]);
    check("sw_level", sw_level, mlev[10:4]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulse"}, btn_pulse, 0);
    check({tag, "_blevel"}, btn_level, 0);
    check({tag, "_swlevel"}, sw_level, 0);
  endtask

  // Called just after a clock edge; release lands mid-cycle.
  task automatic pulse_reset(input int hold);
    reset = 1'b0;
    #1;
    check_zero("rst_async");
    model_reset();
    repeat (hold) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    btn_raw = 4'hf;
    sw_raw = '0;
    repeat_en = 1'b0;
    model_reset();
    n = 0;
    #3;
    check_zero("rst_init");
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (8) cyc();

    // Single press with auto-repeat.
    repeat_en = 1'b1;
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      check("s1_level", btn_level[0], k >= 6);
      check("s1_pulse", btn_pulse[0],
            k == 6 || (k >= 16 && (k - 16) % 3 == 0));
    end
    btn_raw[0] = 1'b1;
    repeat (12) cyc();

    // Short glitch on button 1.
    btn_raw[1] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 4) btn_raw[1] = 1'b1;
      cyc();
      check("s2_level", btn_level[1], 0);
      check("s2_pulse", btn_pulse[1], 0);
    end

    // Switch pattern and a short bounce.
    sw_raw = 7'b1010101;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("s3_sw", sw_level, k >= 6 ? 7'b1010101 : 7'b0);
    end
    sw_raw[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) sw_raw[0] = 1'b1;
      cyc();
      check("s3_bounce", sw_level, 7'b1010101);
    end

    // Simultaneous press, no repeat.
    repeat_en = 1'b0;
    btn_raw = 4'h0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      check("s4_pulse", btn_pulse, k == 6 ? 4'hf : 4'h0);
    end
    btn_raw = 4'hf;
    repeat (12) cyc();

    // Reset while repeating, then repeat_en masking.
    repeat_en = 1'b1;
    btn_raw[2] = 1'b0;
    repeat (25) cyc();
    pulse_reset(3);
    for (int k = 1; k <= 34; k++) begin
      repeat_en = !(k >= 21 && k <= 27);
      cyc();
      if (k <= 8)
        check("s5_pulse", btn_pulse[2], k == 6);
      if (k >= 21 && k <= 27)
        check("s6_masked", btn_pulse[2], 0);
      if (k >= 28)
        check("s6_resume", btn_pulse[2], k % 3 == 1);
    end
    btn_raw[2] = 1'b1;
    repeat (12) cyc();

    // Random stimulus.
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(39) == 0) btn_raw[b] = ~btn_raw[b];
      for (int s = 0; s < 7; s++)
        if ($urandom_range(11) == 0) sw_raw[s] = ~sw_raw[s];
      if ($urandom_range(19) == 0) repeat_en = ~repeat_en;
      if ($urandom_range(599) == 0)
        pulse_reset($urandom_range(1, 3));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
